// File: rtl/bcdr_sop_detector_if.sv
// -----------------------------------------------------------------------------
// bcdr_sop_detector_if
// Signal bundle between the RX datapath / VIO and the burst SOP detector.
//   rx_data_in        RX parallel word, bit 0 received first
//   rx_valid_in       rx_data_in qualifier
//   BCDR_SOP          manual SOP level from VIO (already synchronised)
//   BCDR_sop_sel_vio  1 = manual SOP source, 0 = detected SOP source
//   BCDR_SOP_det_th   transitions-per-word threshold, 0 disables detection
//   sop_out           one-cycle SOP strobe
//   burst_active_out  detector is locked onto a burst
//   trans_count_out   transition count of the last valid word
//   sop_count_out     saturating count of sop_out pulses
// Modports: master = source side (datapath/VIO), slave = detector.
// -----------------------------------------------------------------------------
interface bcdr_sop_detector_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] rx_data_in;
  logic              rx_valid_in;
  logic              BCDR_SOP;
  logic              BCDR_sop_sel_vio;
  logic [6:0]        BCDR_SOP_det_th;
  logic              sop_out;
  logic              burst_active_out;
  logic [6:0]        trans_count_out;
  logic [15:0]       sop_count_out;

  modport master (
    output rx_data_in, rx_valid_in, BCDR_SOP, BCDR_sop_sel_vio, BCDR_SOP_det_th,
    input  sop_out, burst_active_out, trans_count_out, sop_count_out
  );

  modport slave (
    input  rx_data_in, rx_valid_in, BCDR_SOP, BCDR_sop_sel_vio, BCDR_SOP_det_th,
    output sop_out, burst_active_out, trans_count_out, sop_count_out
  );
endinterface

// File: rtl/bcdr_sop_detector.sv
// -----------------------------------------------------------------------------
// bcdr_sop_detector
// Burst-mode start-of-packet detector for the PON upstream RX path. Counts bit
// transitions per word to spot the 1010 preamble, locks after QUAL_WORDS
// qualifying words, drops the burst after GAP_WORDS non-qualifying words, and
// muxes the detected SOP with a manual VIO SOP into a single-cycle strobe.
// Ports:
//   hb0_gtwiz_userclk_rx_usrclk2_int  RX user clock
//   hb_gtwiz_reset_rx_datapath_int    synchronous active-high reset
//   bus                               bcdr_sop_detector_if.slave bundle
// Pipeline: word at edge t -> trans_count_out at t -> det_sop at t+1 ->
//           sop_out at t+2.
// -----------------------------------------------------------------------------
module bcdr_sop_detector #(
  parameter int DATA_W     = 64,
  parameter int QUAL_WORDS = 4,
  parameter int GAP_WORDS  = 8
) (
  input  logic                      hb0_gtwiz_userclk_rx_usrclk2_int,
  input  logic                      hb_gtwiz_reset_rx_datapath_int,
  bcdr_sop_detector_if.slave        bus
);

  localparam int MAX_WORDS = (QUAL_WORDS > GAP_WORDS) ? QUAL_WORDS : GAP_WORDS;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] QUAL_CNT = CNT_W'(QUAL_WORDS);
  localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP_WORDS);

  typedef enum logic [1:0] {IDLE, QUALIFY, LOCKED} state_t;

  // ---------------------------------------------------------------------------
  // Stage 1: transition count
  // ---------------------------------------------------------------------------
  logic              prev_bit;
  logic              v1;
  logic [6:0]        tc_q;
  logic [DATA_W-1:0] diff;
  logic [6:0]        tc;

  // Each bit is compared with its predecessor; bit 0 with the last bit of the
  // previous valid word so preamble runs spanning word boundaries are counted.
  always_comb begin
    diff = bus.rx_data_in ^ {bus.rx_data_in[DATA_W-2:0], prev_bit};
    tc   = '0;
    for (int i = 0; i < DATA_W; i++) tc = tc + 7'(diff[i]);
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values and the simulation matches the synthesized flops.
  always_ff @(posedge hb0_gtwiz_userclk_rx_usrclk2_int) begin
    if (hb_gtwiz_reset_rx_datapath_int) begin
      prev_bit <= 1'b0;
      tc_q     <= '0;
      v1       <= 1'b0;
    end else begin
      v1 <= bus.rx_valid_in;
      if (bus.rx_valid_in) begin
        prev_bit <= bus.rx_data_in[DATA_W-1];
        tc_q     <= tc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: qualification FSM
  // ---------------------------------------------------------------------------
  state_t           state;
  logic [CNT_W-1:0] run;
  logic [CNT_W-1:0] gap;
  logic [6:0]       th_q;
  logic             det_sop;
  logic             burst;
  logic             qual;
  logic [CNT_W-1:0] run_inc;
  logic [CNT_W-1:0] gap_inc;

  assign qual    = (th_q != 7'd0) && (tc_q >= th_q);
  assign run_inc = run + 1'b1;
  assign gap_inc = gap + 1'b1;

  always_ff @(posedge hb0_gtwiz_userclk_rx_usrclk2_int) begin
    if (hb_gtwiz_reset_rx_datapath_int) begin
      state   <= IDLE;
      run     <= '0;
      gap     <= '0;
      th_q    <= '0;
      det_sop <= 1'b0;
      burst   <= 1'b0;
    end else begin
      // NOTE: det_sop is defaulted low every cycle so it can only ever be a
      // single-cycle pulse; each branch below only raises it.
      det_sop <= 1'b0;
      case (state)
        IDLE: begin
          // Threshold is only tracked while idle so a burst in progress is
          // judged against the value it started with.
          th_q <= bus.BCDR_SOP_det_th;
          if (v1 && qual) begin
            gap <= '0;
            if (QUAL_WORDS == 1) begin
              state   <= LOCKED;
              burst   <= 1'b1;
              det_sop <= 1'b1;
              run     <= '0;
            end else begin
              state <= QUALIFY;
              run   <= CNT_W'(1);
            end
          end
        end
        QUALIFY: begin
          if (v1) begin
            if (!qual) begin
              run   <= '0;
              state <= IDLE;
            end else if (run_inc == QUAL_CNT) begin
              run     <= '0;
              gap     <= '0;
              state   <= LOCKED;
              burst   <= 1'b1;
              det_sop <= 1'b1;
            end else begin
              run <= run_inc;
            end
          end
        end
        LOCKED: begin
          if (v1) begin
            if (qual) begin
              gap <= '0;
            end else if (gap_inc == GAP_CNT) begin
              gap   <= '0;
              state <= IDLE;
              burst <= 1'b0;
            end else begin
              gap <= gap_inc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output mux and SOP counter
  // ---------------------------------------------------------------------------
  logic        sop_q;
  logic        sop_r;
  logic [15:0] sop_cnt;

  always_ff @(posedge hb0_gtwiz_userclk_rx_usrclk2_int) begin
    if (hb_gtwiz_reset_rx_datapath_int) begin
      sop_q   <= 1'b0;
      sop_r   <= 1'b0;
      sop_cnt <= '0;
    end else begin
      // Edge register runs regardless of the source select, so switching to
      // the manual source while BCDR_SOP is already high gives no pulse.
      sop_q <= bus.BCDR_SOP;
      sop_r <= bus.BCDR_sop_sel_vio ? (bus.BCDR_SOP & ~sop_q) : det_sop;
      if (sop_r && (sop_cnt != 16'hFFFF)) sop_cnt <= sop_cnt + 16'd1;
    end
  end

  assign bus.sop_out          = sop_r;
  assign bus.burst_active_out = burst;
  assign bus.trans_count_out  = tc_q;
  assign bus.sop_count_out    = sop_cnt;

endmodule
